// File: rtl/capture_buffer_resp_pkg.sv
// Shared types and constants for the CAF capture-buffer responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package capture_buffer_resp_pkg;

   localparam logic BRESP_OKAY   = 1'b0;
   localparam logic BRESP_SLVERR = 1'b1;

   localparam int IQ_I_BITS = 12;
   localparam int IQ_Q_BITS = 12;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wstate_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_t;

   // Packs one I/Q sample into a RAM word, in-phase in the MSBs.
   function automatic logic [IQ_I_BITS+IQ_Q_BITS-1:0] pack_iq(
      input logic [IQ_I_BITS-1:0] i,
      input logic [IQ_Q_BITS-1:0] q
   );
      return {i, q};
   endfunction

endpackage

// File: rtl/capture_buffer_resp_if.sv
// Write/response/read channel bundle between the CAF engine and one capture buffer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every channel; master drives m_axi_*, slave drives s_axi_* and data.
interface capture_buffer_resp_if #(
   parameter int INDEX_BITS = 6,
   parameter int I_BITS     = 12,
   parameter int Q_BITS     = 12
);
   logic [INDEX_BITS-1:0]    m_axi_waddr;
   logic                     m_axi_wvalid;
   logic [I_BITS+Q_BITS-1:0] m_axi_wdata;
   logic                     s_axi_wready;
   logic                     s_axi_bresp;
   logic                     s_axi_bvalid;
   logic                     m_axi_bready;
   logic [INDEX_BITS-1:0]    m_axi_raddr;
   logic                     m_axi_rvalid;
   logic                     s_axi_rready;
   logic                     s_axi_rvalid;
   logic [I_BITS-1:0]        out_i;
   logic [Q_BITS-1:0]        out_q;
   logic                     m_axi_rready;

   modport master (
      output m_axi_waddr, m_axi_wvalid, m_axi_wdata, m_axi_bready,
      output m_axi_raddr, m_axi_rvalid, m_axi_rready,
      input  s_axi_wready, s_axi_bresp, s_axi_bvalid,
      input  s_axi_rready, s_axi_rvalid, out_i, out_q
   );

   modport slave (
      input  m_axi_waddr, m_axi_wvalid, m_axi_wdata, m_axi_bready,
      input  m_axi_raddr, m_axi_rvalid, m_axi_rready,
      output s_axi_wready, s_axi_bresp, s_axi_bvalid,
      output s_axi_rready, s_axi_rvalid, out_i, out_q
   );
endinterface

// File: rtl/capture_buffer_resp_dp_ram.sv
// Sample store: one synchronous write port, one registered read port (read-before-write).
// Latency: write lands at the edge; read data valid one edge after i_re.
// Backpressure: none; read register holds its value until the next i_re.
module capture_buffer_resp_dp_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int DW    = 24
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic          i_rclr,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   // Storage array: no reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read register samples the pre-write word; only loads on a read so it holds under stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= i_rclr ? '0 : r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/capture_buffer_resp.sv
// Memory-side responder for a CAF capture buffer: single-word I/Q writes and addressed reads.
// Latency: write response and read data both one edge after the handshake.
// Backpressure: each channel holds its response/data and drops ready until the initiator accepts.
module capture_buffer_resp
   import capture_buffer_resp_pkg::*;
#(
   parameter int BUFFER_LENGTH = 64,
   // May exceed clog2(BUFFER_LENGTH) so that out-of-range addresses are expressible.
   parameter int INDEX_BITS    = 6,
   parameter int I_BITS        = 12,
   parameter int Q_BITS        = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   capture_buffer_resp_if.slave   io_bus
);

   localparam int          RAM_AW = (BUFFER_LENGTH > 1) ? $clog2(BUFFER_LENGTH) : 1;
   localparam int          DW     = I_BITS + Q_BITS;
   localparam logic [31:0] LEN_U  = 32'(BUFFER_LENGTH);

   wstate_t r_wstate, w_wstate_nxt;
   rstate_t r_rstate, w_rstate_nxt;

   logic r_wready, w_wready_nxt;
   logic r_bvalid, w_bvalid_nxt;
   logic r_bresp,  w_bresp_nxt;
   logic r_rready, w_rready_nxt;
   logic r_rvalid, w_rvalid_nxt;

   logic          w_waddr_oob;
   logic          w_raddr_oob;
   logic          w_wr_hs;
   logic          w_rd_hs;
   logic          w_ram_we;
   logic [DW-1:0] w_rdata;

   // Addresses are never aliased: anything at or past the buffer end is an error.
   assign w_waddr_oob = (32'(io_bus.m_axi_waddr) >= LEN_U);
   assign w_raddr_oob = (32'(io_bus.m_axi_raddr) >= LEN_U);
   assign w_wr_hs     = io_bus.m_axi_wvalid & r_wready;
   assign w_rd_hs     = io_bus.m_axi_rvalid & r_rready;
   assign w_ram_we    = w_wr_hs & ~w_waddr_oob;

   capture_buffer_resp_dp_ram #(
      .DEPTH (BUFFER_LENGTH),
      .AW    (RAM_AW),
      .DW    (DW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_ram_we),
      .i_waddr (io_bus.m_axi_waddr[RAM_AW-1:0]),
      .i_wdata (io_bus.m_axi_wdata),
      .i_re    (w_rd_hs),
      .i_rclr  (w_raddr_oob),
      .i_raddr (io_bus.m_axi_raddr[RAM_AW-1:0]),
      .o_rdata (w_rdata)
   );

   // Write FSM state and registered write-channel outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wstate <= W_IDLE;
         r_wready <= 1'b0;
         r_bvalid <= 1'b0;
         r_bresp  <= BRESP_OKAY;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_wready <= w_wready_nxt;
         r_bvalid <= w_bvalid_nxt;
         r_bresp  <= w_bresp_nxt;
      end
   end

   // Write FSM: accept one word, then hold the response until it is taken.
   always_comb begin
      w_wstate_nxt = r_wstate;
      w_wready_nxt = r_wready;
      w_bvalid_nxt = r_bvalid;
      w_bresp_nxt  = r_bresp;
      case (r_wstate)
         W_IDLE: begin
            w_wready_nxt = 1'b1;
            if (w_wr_hs) begin
               w_wstate_nxt = W_RESP;
               w_wready_nxt = 1'b0;
               w_bvalid_nxt = 1'b1;
               w_bresp_nxt  = w_waddr_oob ? BRESP_SLVERR : BRESP_OKAY;
            end
         end
         W_RESP: begin
            if (r_bvalid && io_bus.m_axi_bready) begin
               w_wstate_nxt = W_IDLE;
               w_wready_nxt = 1'b1;
               w_bvalid_nxt = 1'b0;
               w_bresp_nxt  = BRESP_OKAY;
            end
         end
         default: begin
            w_wstate_nxt = W_IDLE;
         end
      endcase
   end

   // Read FSM state and registered read-channel handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rstate <= R_IDLE;
         r_rready <= 1'b0;
         r_rvalid <= 1'b0;
      end else begin
         r_rstate <= w_rstate_nxt;
         r_rready <= w_rready_nxt;
         r_rvalid <= w_rvalid_nxt;
      end
   end

   // Read FSM: take one address, then hold the data beat until it is taken.
   always_comb begin
      w_rstate_nxt = r_rstate;
      w_rready_nxt = r_rready;
      w_rvalid_nxt = r_rvalid;
      case (r_rstate)
         R_IDLE: begin
            w_rready_nxt = 1'b1;
            if (w_rd_hs) begin
               w_rstate_nxt = R_DATA;
               w_rready_nxt = 1'b0;
               w_rvalid_nxt = 1'b1;
            end
         end
         R_DATA: begin
            if (r_rvalid && io_bus.m_axi_rready) begin
               w_rstate_nxt = R_IDLE;
               w_rready_nxt = 1'b1;
               w_rvalid_nxt = 1'b0;
            end
         end
         default: begin
            w_rstate_nxt = R_IDLE;
         end
      endcase
   end

   assign io_bus.s_axi_wready = r_wready;
   assign io_bus.s_axi_bvalid = r_bvalid;
   assign io_bus.s_axi_bresp  = r_bresp;
   assign io_bus.s_axi_rready = r_rready;
   assign io_bus.s_axi_rvalid = r_rvalid;
   assign io_bus.out_i        = w_rdata[DW-1:Q_BITS];
   assign io_bus.out_q        = w_rdata[Q_BITS-1:0];

endmodule

// File: tb/tb_capture_buffer_resp.sv
// Bench for capture_buffer_resp: random and directed transactions against a word-array model.
// Latency: expects responses one edge after each handshake.
// Backpressure: stalls bready/rready and checks held outputs.
module tb_capture_buffer_resp;
   import capture_buffer_resp_pkg::*;

   localparam int LEN = 64;
   localparam int AB  = 7;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   logic [23:0] mdl [LEN];

   capture_buffer_resp_if #(.INDEX_BITS(AB), .I_BITS(12), .Q_BITS(12)) bus ();

   capture_buffer_resp #(
      .BUFFER_LENGTH (LEN),
      .INDEX_BITS    (AB),
      .I_BITS        (12),
      .Q_BITS        (12)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] exp_word(input int addr);
      if (addr < LEN) return mdl[addr];
      return 24'h0;
   endfunction

   task automatic wait_wready();
      for (int k = 0; k < 20 && bus.s_axi_wready !== 1'b1; k++) step();
      check_eq("wready_wait", 32'(bus.s_axi_wready), 1);
   endtask

   task automatic wait_rready();
      for (int k = 0; k < 20 && bus.s_axi_rready !== 1'b1; k++) step();
      check_eq("rready_wait", 32'(bus.s_axi_rready), 1);
   endtask

   task automatic do_write(input int addr, input logic [23:0] data, input int stall);
      logic [AB-1:0] a;
      a = addr[AB-1:0];
      wait_wready();
      bus.m_axi_bready = (stall == 0);
      bus.m_axi_wvalid = 1'b1;
      bus.m_axi_waddr  = a;
      bus.m_axi_wdata  = data;
      step();
      bus.m_axi_wvalid = 1'b0;
      if (addr < LEN) mdl[addr] = data;
      check_eq("wr_bvalid", 32'(bus.s_axi_bvalid), 1);
      check_eq("wr_bresp", 32'(bus.s_axi_bresp), (addr >= LEN) ? 1 : 0);
      check_eq("wr_wready_low", 32'(bus.s_axi_wready), 0);
      for (int k = 0; k < stall; k++) begin
         // Junk writes while wready is low must be ignored.
         bus.m_axi_wvalid = 1'b1;
         bus.m_axi_waddr  = 7'($urandom_range(0, 127));
         bus.m_axi_wdata  = 24'($urandom);
         step();
         check_eq("stall_bvalid", 32'(bus.s_axi_bvalid), 1);
         check_eq("stall_bresp", 32'(bus.s_axi_bresp), (addr >= LEN) ? 1 : 0);
         check_eq("stall_wready", 32'(bus.s_axi_wready), 0);
      end
      bus.m_axi_bready = 1'b1;
      step();
      bus.m_axi_wvalid = 1'b0;
      bus.m_axi_bready = 1'b0;
      check_eq("wr_done_bvalid", 32'(bus.s_axi_bvalid), 0);
      check_eq("wr_done_bresp", 32'(bus.s_axi_bresp), 0);
      check_eq("wr_done_wready", 32'(bus.s_axi_wready), 1);
   endtask

   task automatic do_read(input int addr, input int stall, input bit rewrite);
      logic [23:0] exp;
      logic [23:0] nw;
      bit          did;
      did = 1'b0;
      wait_rready();
      exp = exp_word(addr);
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_raddr  = addr[AB-1:0];
      step();
      bus.m_axi_rvalid = 1'b0;
      check_eq("rd_rvalid", 32'(bus.s_axi_rvalid), 1);
      check_eq("rd_out_i", 32'(bus.out_i), 32'(exp[23:12]));
      check_eq("rd_out_q", 32'(bus.out_q), 32'(exp[11:0]));
      check_eq("rd_rready_low", 32'(bus.s_axi_rready), 0);
      for (int k = 0; k < stall; k++) begin
         did = 1'b0;
         if (k == 0 && rewrite && addr < LEN && bus.s_axi_wready === 1'b1) begin
            nw = 24'($urandom);
            bus.m_axi_wvalid = 1'b1;
            bus.m_axi_waddr  = addr[AB-1:0];
            bus.m_axi_wdata  = nw;
            bus.m_axi_bready = 1'b1;
            did = 1'b1;
         end
         // Junk read requests while rready is low must be ignored.
         bus.m_axi_rvalid = 1'b1;
         bus.m_axi_raddr  = 7'($urandom_range(0, 127));
         step();
         bus.m_axi_wvalid = 1'b0;
         if (did) mdl[addr] = nw;
         check_eq("hold_rvalid", 32'(bus.s_axi_rvalid), 1);
         check_eq("hold_out_i", 32'(bus.out_i), 32'(exp[23:12]));
         check_eq("hold_out_q", 32'(bus.out_q), 32'(exp[11:0]));
      end
      bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rready = 1'b1;
      step();
      bus.m_axi_rready = 1'b0;
      bus.m_axi_bready = 1'b0;
      check_eq("rd_done_rvalid", 32'(bus.s_axi_rvalid), 0);
      check_eq("rd_done_rready", 32'(bus.s_axi_rready), 1);
   endtask

   task automatic sweep();
      for (int a = 0; a < LEN + 16; a++) do_read(a, 0, 1'b0);
   endtask

   initial begin
      logic [23:0] d;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus.m_axi_waddr  = '0;
      bus.m_axi_wvalid = 1'b0;
      bus.m_axi_wdata  = '0;
      bus.m_axi_bready = 1'b0;
      bus.m_axi_raddr  = '0;
      bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rready = 1'b0;

      // Reset state, then readies rise on the first edge after release.
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_wready", 32'(bus.s_axi_wready), 0);
      check_eq("rst_bvalid", 32'(bus.s_axi_bvalid), 0);
      check_eq("rst_bresp", 32'(bus.s_axi_bresp), 0);
      check_eq("rst_rready", 32'(bus.s_axi_rready), 0);
      check_eq("rst_rvalid", 32'(bus.s_axi_rvalid), 0);
      check_eq("rst_out_i", 32'(bus.out_i), 0);
      check_eq("rst_out_q", 32'(bus.out_q), 0);
      #3 rst_n = 1'b1;
      #1;
      check_eq("rel_wready_pre_edge", 32'(bus.s_axi_wready), 0);
      step();
      check_eq("rel_wready", 32'(bus.s_axi_wready), 1);
      check_eq("rel_rready", 32'(bus.s_axi_rready), 1);
      check_eq("rel_bvalid", 32'(bus.s_axi_bvalid), 0);

      // Fill the buffer so every in-range read has a defined expectation.
      for (int a = 0; a < LEN; a++) do_write(a, 24'($urandom), 0);

      // Basic write/read of a known word.
      do_write(5, pack_iq(12'hABC, 12'h123), 0);
      do_read(5, 0, 1'b0);
      check_eq("known_word_mdl", 32'(mdl[5]), 32'h00ABC123);

      // Out-of-range write and read, then full sweep.
      do_write(70, 24'hFFFFFF, 0);
      do_read(70, 0, 1'b0);
      sweep();

      // Backpressure on both channels, with a rewrite under a stalled read.
      do_write(12, 24'($urandom), 10);
      do_read(12, 10, 1'b1);
      do_read(12, 0, 1'b0);

      // Same-edge read and write of one address returns the old word.
      do_write(9, pack_iq(12'h333, 12'h444), 0);
      bus.m_axi_wvalid = 1'b1;
      bus.m_axi_waddr  = 7'd9;
      bus.m_axi_wdata  = pack_iq(12'h111, 12'h222);
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_raddr  = 7'd9;
      bus.m_axi_bready = 1'b1;
      step();
      bus.m_axi_wvalid = 1'b0;
      bus.m_axi_rvalid = 1'b0;
      check_eq("same_edge_out_i", 32'(bus.out_i), 32'h333);
      check_eq("same_edge_out_q", 32'(bus.out_q), 32'h444);
      check_eq("same_edge_bvalid", 32'(bus.s_axi_bvalid), 1);
      check_eq("same_edge_rvalid", 32'(bus.s_axi_rvalid), 1);
      mdl[9] = pack_iq(12'h111, 12'h222);
      bus.m_axi_rready = 1'b1;
      step();
      bus.m_axi_rready = 1'b0;
      bus.m_axi_bready = 1'b0;
      check_eq("same_edge_done_b", 32'(bus.s_axi_bvalid), 0);
      check_eq("same_edge_done_r", 32'(bus.s_axi_rvalid), 0);
      do_read(9, 0, 1'b0);

      // Random mix of reads and writes, including out-of-range and stalls.
      for (int n = 0; n < 200; n++) begin
         int a;
         int s;
         a = $urandom_range(0, LEN + 15);
         s = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 0) do_write(a, 24'($urandom), s);
         else do_read(a, s, 1'($urandom_range(0, 1)));
      end

      // Reset with both responses pending: drops asynchronously, completed write kept.
      d = 24'($urandom);
      bus.m_axi_wvalid = 1'b1;
      bus.m_axi_waddr  = 7'd20;
      bus.m_axi_wdata  = d;
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_raddr  = 7'd30;
      step();
      bus.m_axi_wvalid = 1'b0;
      bus.m_axi_rvalid = 1'b0;
      mdl[20] = d;
      check_eq("pre_rst_bvalid", 32'(bus.s_axi_bvalid), 1);
      check_eq("pre_rst_rvalid", 32'(bus.s_axi_rvalid), 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_bvalid", 32'(bus.s_axi_bvalid), 0);
      check_eq("async_rvalid", 32'(bus.s_axi_rvalid), 0);
      check_eq("async_wready", 32'(bus.s_axi_wready), 0);
      check_eq("async_rready", 32'(bus.s_axi_rready), 0);
      check_eq("async_out_i", 32'(bus.out_i), 0);
      check_eq("async_out_q", 32'(bus.out_q), 0);
      step();
      #2 rst_n = 1'b1;
      bus.m_axi_bready = 1'b1;
      bus.m_axi_rready = 1'b1;
      step();
      check_eq("post_rst_wready", 32'(bus.s_axi_wready), 1);
      check_eq("post_rst_bvalid", 32'(bus.s_axi_bvalid), 0);
      check_eq("post_rst_rvalid", 32'(bus.s_axi_rvalid), 0);
      step();
      check_eq("no_late_bvalid", 32'(bus.s_axi_bvalid), 0);
      check_eq("no_late_rvalid", 32'(bus.s_axi_rvalid), 0);
      bus.m_axi_bready = 1'b0;
      bus.m_axi_rready = 1'b0;
      sweep();

      // Back-to-back writes over the whole buffer, then verify.
      for (int a = 0; a < LEN; a++) do_write(a, 24'($urandom), 0);
      sweep();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
